// File: rtl/priority_arbiter_pkg.sv
// Shared types and default sizing for the priority arbiter slice.
package arb_pkg;

   localparam int N     = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/priority_arbiter_if.sv
// Requester/arbiter bundle: request side driven by the master, grant side by the arbiter.
interface arb_if
   import arb_pkg::*;
#(
   parameter int N     = arb_pkg::N,
   parameter int IDX_W = arb_pkg::IDX_W
);

   logic             enable;
   logic             rr_mode;
   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output enable, rr_mode, req,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  enable, rr_mode, req,
      output grant, grant_idx, grant_valid, timeout
   );

endinterface

// File: rtl/priority_arbiter_pick.sv
// Combinational descending search over the eligible mask, starting at a given index and wrapping.
module priority_pick #(
   parameter int N     = arb_pkg::N,
   parameter int IDX_W = arb_pkg::IDX_W
) (
   input  logic [N-1:0]     elig,
   input  logic [IDX_W-1:0] start,
   input  logic             rr_mode,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   int s;
   int j;

   // Walk from lowest to highest priority so the last hit overwrites; fixed mode is start = N-1.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      s     = rr_mode ? int'(start) : N - 1;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (s + N - k) % N;
         if (elig[j]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/priority_arbiter.sv
// Eight-way arbiter with fixed/round-robin selection, grant hold, hold-limit timeout and blocking.
module priority_arbiter
   import arb_pkg::*;
#(
   parameter int N        = arb_pkg::N,
   parameter int IDX_W    = arb_pkg::IDX_W,
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input logic clk,
   input logic rst_n,
   arb_if.slave bus
);

   arb_state_t       state;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] last_idx;
   logic [N-1:0]     blocked;
   logic [N-1:0]     grant_r;
   logic [IDX_W-1:0] grant_idx_r;
   logic             grant_valid_r;
   logic             timeout_r;

   logic [N-1:0]     elig;
   logic [IDX_W-1:0] start_idx;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;

   assign elig      = bus.req & ~blocked;
   assign start_idx = (last_idx == '0) ? IDX_W'(N - 1) : last_idx - IDX_W'(1);

   priority_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig    (elig),
      .start   (start_idx),
      .rr_mode (bus.rr_mode),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   // Blocks lift whenever the requester drops; a timeout re-blocks the current holder on top of that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         last_idx      <= '0;
         blocked       <= '0;
         grant_r       <= '0;
         grant_idx_r   <= '0;
         grant_valid_r <= 1'b0;
         timeout_r     <= 1'b0;
      end else begin
         timeout_r <= 1'b0;
         blocked   <= blocked & bus.req;
         case (state)
            IDLE: begin
               if (bus.enable && pick_found) begin
                  state         <= GRANT;
                  grant_r       <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                  grant_idx_r   <= pick_idx;
                  grant_valid_r <= 1'b1;
                  hold_cnt      <= '0;
                  last_idx      <= pick_idx;
               end
            end
            GRANT: begin
               if (!bus.enable) begin
                  state         <= IDLE;
                  grant_r       <= '0;
                  grant_idx_r   <= '0;
                  grant_valid_r <= 1'b0;
               end else if (!bus.req[grant_idx_r]) begin
                  state         <= GAP;
                  grant_r       <= '0;
                  grant_idx_r   <= '0;
                  grant_valid_r <= 1'b0;
               end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                  state         <= GAP;
                  grant_r       <= '0;
                  grant_idx_r   <= '0;
                  grant_valid_r <= 1'b0;
                  timeout_r     <= 1'b1;
                  blocked       <= (blocked & bus.req) | grant_r;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_idx   = grant_idx_r;
   assign bus.grant_valid = grant_valid_r;
   assign bus.timeout     = timeout_r;

endmodule
